fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter and fetch front end that sits directly upstream of the instruction decoder.
- Drives the word address into the synchronous instruction memory (one-cycle read latency).
- Tracks the in-flight request and presents each fetched word with its address to decode over a valid/ready handshake.
- Holds a one-entry skid buffer so back-pressure never loses or duplicates a word.
- Accepts jump redirects that flush all in-flight and buffered words.

Parameters:
WORD_SIZE, 16, width of instruction words and addresses
RESET_VECTOR, 0, address of the first fetch after reset

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
mem_addr  out  WORD_SIZE  address to instruction memory; equals pc register (combinational)
mem_data  in  WORD_SIZE  memory read data, valid the cycle after its address is sampled
instr_out  out  WORD_SIZE  instruction word to decode
instr_pc  out  WORD_SIZE  address of instr_out
instr_valid  out  1  instr_out/instr_pc hold a valid word
instr_ready  in  1  decode accepts the word this cycle
jump_en  in  1  redirect request
jump_target  in  WORD_SIZE  redirect address

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VECTOR, inflight=0, skid_valid=0, instr_valid=0, instr_out=0, instr_pc=0. Takes effect without a clock edge.
- State:
  - pc: the next address to request.
  - inflight flag plus inflight_pc: set when the word on mem_data this cycle belongs to a request.
  - Output register: instr_out, instr_pc, instr_valid.
  - Skid register: skid_instr, skid_pc, skid_valid.
- Handshake: a transfer happens when instr_valid && instr_ready. While instr_valid=1 and instr_ready=0, instr_out and instr_pc must not change (except on jump or reset).
- Occupancy: occ = instr_valid + skid_valid + inflight − (transfer ? 1 : 0).
- Issue: a request issues when occ < 2 and jump_en=0.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1 (modulo 2^WORD_SIZE; 0xFFFF wraps to 0x0000).
  - Otherwise inflight<=0 and pc holds.
- Return (inflight=1, mem_data valid), priority order:
  - Output empty or transferring, and skid empty → mem_data loads output register.
  - Output empty or transferring, and skid full → skid moves to output; mem_data loads skid.
  - Output full and not transferring → mem_data loads skid. Skid is guaranteed empty by the issue rule.
- Drain: on transfer with no return, a valid skid moves to output; otherwise instr_valid<=0.
- Ordering: words leave in strictly increasing address order (modulo wrap) between redirects. No word is dropped or duplicated.
- Jump (jump_en=1) overrides all updates that cycle:
  - pc<=jump_target, inflight<=0, skid_valid<=0, instr_valid<=0.
  - A transfer occurring in the same cycle still counts as accepted by decode.
  - The first request from jump_target issues the next cycle; its word reaches the output two edges after that.
  - jump_en held high for multiple cycles re-redirects each cycle and nothing issues.
- Latency:
  - Reset release to first instr_valid: 2 rising edges.
  - Jump cycle to first new instr_valid: 3 rising edges.
  - Steady-state throughput with instr_ready=1: one word per cycle.
- mem_data is ignored whenever inflight=0.

Test Plan:
- Reset release, instr_ready=1, mem[i]=0x1000+i → instr_valid rises after 2nd edge; instr_pc 0,1,2,3… and instr_out 0x1000,0x1001… on consecutive cycles, no bubbles.
- instr_ready=0 for 3 cycles while instr_pc=4 → instr_out holds 0x1004 and mem_addr stalls. On release, 0x1004, 0x1005, 0x1006 delivered back to back, none lost or repeated.
- Skid full (instr_ready low at pc 7), jump_en with jump_target=0x0040 → instr_valid=0 next cycle. Next delivered instr_pc=0x0040 exactly 3 edges after the jump cycle; no word from 0x0007–0x0009 ever appears.
- jump_en together with a transfer of instr_pc=0x0010 → 0x0010 counts as accepted and is not re-presented; stream resumes at target.
- Jump to 0xFFFE with ready=1 → delivered instr_pc 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- reset_n pulsed low mid-clock during streaming → instr_valid=0 and mem_addr=RESET_VECTOR immediately, before any edge. After release, stream restarts at RESET_VECTOR with 2-edge latency.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC and fetch front end with one-entry skid buffer and jump redirect
module fetch_sequencer #(
   parameter int                   WORD_SIZE    = 16,
   parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic [WORD_SIZE-1:0] mem_addr,
   input  logic [WORD_SIZE-1:0] mem_data,
   output logic [WORD_SIZE-1:0] instr_out,
   output logic [WORD_SIZE-1:0] instr_pc,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   input  logic                 jump_en,
   input  logic [WORD_SIZE-1:0] jump_target
);

   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic                 inflight_q, inflight_d;
   logic [WORD_SIZE-1:0] inflight_pc_q, inflight_pc_d;
   logic [WORD_SIZE-1:0] instr_q, instr_d;
   logic [WORD_SIZE-1:0] instr_pc_q, instr_pc_d;
   logic                 instr_valid_q, instr_valid_d;
   logic [WORD_SIZE-1:0] skid_instr_q, skid_instr_d;
   logic [WORD_SIZE-1:0] skid_pc_q, skid_pc_d;
   logic                 skid_valid_q, skid_valid_d;

   logic                 transfer;
   logic                 issue;
   logic [1:0]           occ;

   assign mem_addr    = pc_q;
   assign instr_out   = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

   // Words held or owed after this cycle's transfer; two slots exist (output + skid).
   assign transfer = instr_valid_q && instr_ready;
   assign occ      = 2'(instr_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(transfer);
   assign issue    = (occ < 2'd2) && !jump_en;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      skid_instr_d  = skid_instr_q;
      skid_pc_d     = skid_pc_q;
      skid_valid_d  = skid_valid_q;

      if (jump_en) begin
         pc_d          = jump_target;
         inflight_d    = 1'b0;
         skid_valid_d  = 1'b0;
         instr_valid_d = 1'b0;
      end else begin
         if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 1'b1;
         end else begin
            inflight_d = 1'b0;
         end

         if (inflight_q) begin
            if (!instr_valid_q || transfer) begin
               if (!skid_valid_q) begin
                  instr_d       = mem_data;
                  instr_pc_d    = inflight_pc_q;
                  instr_valid_d = 1'b1;
               end else begin
                  // Older skid word goes out first; the returning word takes its place.
                  instr_d       = skid_instr_q;
                  instr_pc_d    = skid_pc_q;
                  instr_valid_d = 1'b1;
                  skid_instr_d  = mem_data;
                  skid_pc_d     = inflight_pc_q;
               end
            end else begin
               skid_instr_d = mem_data;
               skid_pc_d    = inflight_pc_q;
               skid_valid_d = 1'b1;
            end
         end else if (transfer) begin
            if (skid_valid_q) begin
               instr_d       = skid_instr_q;
               instr_pc_d    = skid_pc_q;
               instr_valid_d = 1'b1;
               skid_valid_d  = 1'b0;
            end else begin
               instr_valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q          <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         skid_instr_q  <= '0;
         skid_pc_q     <= '0;
         skid_valid_q  <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         skid_instr_q  <= skid_instr_d;
         skid_pc_q     <= skid_pc_d;
         skid_valid_q  <= skid_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic [15:0] instr_out;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump_en;
   logic [15:0] jump_target;

   int errors = 0;
   int checks = 0;

   fetch_sequencer #(.WORD_SIZE(16), .RESET_VECTOR(16'h0000)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump_en     (jump_en),
      .jump_target (jump_target)
   );

   always #5 clk = ~clk;

   // Synchronous memory: mem[a] = 0x1000 + a, one-cycle read latency
   always @(posedge clk) mem_data <= 16'h1000 + mem_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_word(input string tag, input logic [15:0] pc);
      logic [15:0] word;
      word = 16'h1000 + pc;
      chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
      chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
      chk({tag, "_out"}, 32'(instr_out), 32'(word));
   endtask

   task automatic expect_empty(input string tag);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      instr_ready = 1'b1;
      jump_en     = 1'b0;
      jump_target = 16'h0000;

      @(negedge clk);
      expect_empty("rst");
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_out", 32'(instr_out), 32'h0);
      chk("rst_pc", 32'(instr_pc), 32'h0);

      reset_n = 1'b1;
      tick();
      expect_empty("lat1");
      chk("lat1_addr", 32'(mem_addr), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_word("stream", 16'(i));
      end

      // Stall with 0x1004 presented
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_word("stall", 16'h0004);
         chk("stall_addr", 32'(mem_addr), 32'h6);
      end
      instr_ready = 1'b1;
      for (int i = 5; i < 8; i++) begin
         tick();
         expect_word("resume", 16'(i));
      end

      // Fill skid behind 0x0007, then redirect
      instr_ready = 1'b0;
      tick();
      expect_word("skidfull", 16'h0007);
      chk("skidfull_addr", 32'(mem_addr), 32'h9);
      jump_en     = 1'b1;
      jump_target = 16'h0040;
      tick();
      jump_en     = 1'b0;
      instr_ready = 1'b1;
      expect_empty("jmp1");
      chk("jmp1_addr", 32'(mem_addr), 32'h40);
      tick();
      expect_empty("jmp2");
      tick();
      expect_word("jmp3", 16'h0040);
      tick();
      expect_word("jmp4", 16'h0041);
      tick();
      expect_word("jmp5", 16'h0042);

      jump_en     = 1'b1;
      jump_target = 16'h000E;
      tick();
      jump_en = 1'b0;
      expect_empty("j2a");
      tick();
      expect_empty("j2b");
      for (int i = 14; i < 17; i++) begin
         tick();
         expect_word("j2s", 16'(i));
      end

      // Jump in the same cycle that 0x0010 transfers
      jump_en     = 1'b1;
      jump_target = 16'h0100;
      tick();
      jump_en = 1'b0;
      expect_empty("jx1");
      tick();
      expect_empty("jx2");
      tick();
      expect_word("jx3", 16'h0100);
      tick();
      expect_word("jx4", 16'h0101);

      // Held jump re-redirects each cycle and issues nothing
      jump_en     = 1'b1;
      jump_target = 16'h2222;
      tick();
      expect_empty("hold1");
      chk("hold1_addr", 32'(mem_addr), 32'h2222);
      jump_target = 16'hFFFE;
      tick();
      jump_en = 1'b0;
      expect_empty("hold2");
      chk("hold2_addr", 32'(mem_addr), 32'hFFFE);
      tick();
      expect_empty("hold3");
      chk("hold3_addr", 32'(mem_addr), 32'hFFFF);
      tick();
      expect_word("wrap0", 16'hFFFE);
      tick();
      expect_word("wrap1", 16'hFFFF);
      tick();
      expect_word("wrap2", 16'h0000);
      tick();
      expect_word("wrap3", 16'h0001);

      // Asynchronous reset mid-cycle while streaming
      #2 reset_n = 1'b0;
      #1;
      expect_empty("arst");
      chk("arst_addr", 32'(mem_addr), 32'h0);
      chk("arst_pc", 32'(instr_pc), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      expect_empty("rel1");
      chk("rel1_addr", 32'(mem_addr), 32'h1);
      tick();
      expect_word("rel2", 16'h0000);
      tick();
      expect_word("rel3", 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
